bit_stream_serializer: RTL and testbench

//   Upstream feeder for the 1101 Mealy sequence detector. Accepts a parallel word through a valid/ready

---
 rtl/bit_stream_serializer_if.sv | 27 ++
 rtl/bit_stream_serializer.sv | 137 +++++++++++++
 tb/tb_bit_stream_serializer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bit_stream_serializer_if.sv
// Word-load handshake and serial bit stream bundle for bit_stream_serializer.
// The word source drives the load_* fields and stall; the serializer drives the rest.
interface bit_stream_serializer_if #(
    parameter int WIDTH = 8
);
    localparam int LEN_W = $clog2(WIDTH + 1);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic             stall;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_data, load_len, stall,
        input  load_ready, ser_out, ser_valid, busy, done
    );

    modport slave (
        input  load_valid, load_data, load_len, stall,
        output load_ready, ser_out, ser_valid, busy, done
    );
endinterface

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder: takes a word of up to WIDTH bits through valid/ready and
// emits it one bit per clock with a per-bit strobe and an end-of-word done pulse.
module bit_stream_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    bit_stream_serializer_if.slave bus
);
    localparam int LEN_W = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [LEN_W-1:0] len_q, len_nxt;
    logic             ser_out_q, ser_out_nxt;
    logic             ser_valid_q, ser_valid_nxt;
    logic             done_q, done_nxt;
    logic [LEN_W-1:0] len_eff;
    logic [WIDTH-1:0] word;

    // Lengths above WIDTH are clamped rather than wrapped.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        if (int'(len) > WIDTH)
            return LEN_W'(WIDTH);
        else
            return len;
    endfunction

    // Drop bits above len; for MSB-first the first bit is moved up to the top position.
    function automatic logic [WIDTH-1:0] align_word(input logic [WIDTH-1:0] data,
                                                    input logic [LEN_W-1:0] len);
        logic [WIDTH-1:0] masked;
        masked = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(len))
                masked[i] = data[i];
        end
        if (MSB_FIRST)
            return masked << (WIDTH - int'(len));
        else
            return masked;
    endfunction

    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift_reg;
        cnt_nxt       = cnt;
        len_nxt       = len_q;
        ser_out_nxt   = ser_out_q;
        ser_valid_nxt = 1'b0;
        done_nxt      = 1'b0;
        len_eff       = sat_len(bus.load_len);
        word          = align_word(bus.load_data, len_eff);

        case (state)
            IDLE: begin
                ser_out_nxt = IDLE_LEVEL;
                if (bus.load_valid) begin
                    len_nxt = len_eff;
                    if (len_eff == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt     = SHIFT;
                        cnt_nxt       = LEN_W'(1);
                        ser_valid_nxt = 1'b1;
                        if (MSB_FIRST) begin
                            ser_out_nxt = word[WIDTH-1];
                            shift_nxt   = word << 1;
                        end else begin
                            ser_out_nxt = word[0];
                            shift_nxt   = word >> 1;
                        end
                    end
                end
            end
            SHIFT: begin
                // A stalled edge holds everything and only drops the strobe.
                if (!bus.stall) begin
                    if (cnt == len_q) begin
                        state_nxt   = IDLE;
                        done_nxt    = 1'b1;
                        ser_out_nxt = IDLE_LEVEL;
                        cnt_nxt     = '0;
                        shift_nxt   = '0;
                    end else begin
                        ser_valid_nxt = 1'b1;
                        cnt_nxt       = cnt + LEN_W'(1);
                        if (MSB_FIRST) begin
                            ser_out_nxt = shift_reg[WIDTH-1];
                            shift_nxt   = shift_reg << 1;
                        end else begin
                            ser_out_nxt = shift_reg[0];
                            shift_nxt   = shift_reg >> 1;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            cnt         <= '0;
            len_q       <= '0;
            ser_out_q   <= IDLE_LEVEL;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            shift_reg   <= shift_nxt;
            cnt         <= cnt_nxt;
            len_q       <= len_nxt;
            ser_out_q   <= ser_out_nxt;
            ser_valid_q <= ser_valid_nxt;
            done_q      <= done_nxt;
        end
    end

    assign bus.load_ready = (state == IDLE);
    assign bus.busy       = (state == SHIFT);
    assign bus.ser_out    = ser_out_q;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench for bit_stream_serializer: one MSB-first and one LSB-first instance.
module tb_bit_stream_serializer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [7:0] pat;

    bit_stream_serializer_if #(.WIDTH(8)) m_if ();
    bit_stream_serializer_if #(.WIDTH(8)) l_if ();

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (m_if.slave)
    );

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (l_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic vld, input logic out, input logic exp);
        chk({tag, "_valid"}, 32'(vld), 32'd1);
        chk({tag, "_data"}, 32'(out), 32'(exp));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        m_if.load_valid = 1'b0; m_if.load_data = '0; m_if.load_len = '0; m_if.stall = 1'b0;
        l_if.load_valid = 1'b0; l_if.load_data = '0; l_if.load_len = '0; l_if.stall = 1'b0;

        // Reset state
        step; step;
        chk("rst_ready", 32'(m_if.load_ready), 32'd1);
        chk("rst_valid", 32'(m_if.ser_valid), 32'd0);
        chk("rst_busy",  32'(m_if.busy), 32'd0);
        chk("rst_done",  32'(m_if.done), 32'd0);
        chk("rst_out",   32'(m_if.ser_out), 32'd0);
        reset = 1'b1;
        step;

        // 1101, MSB first, no stall
        m_if.load_data = 8'h0D; m_if.load_len = 4'd4; m_if.load_valid = 1'b1;
        step;
        m_if.load_valid = 1'b0;
        pat = 8'h0D;
        for (int i = 0; i < 4; i++) begin
            chk_bit($sformatf("t2_bit%0d", i), m_if.ser_valid, m_if.ser_out, pat[3-i]);
            chk($sformatf("t2_ready%0d", i), 32'(m_if.load_ready), 32'd0);
            step;
        end
        chk("t2_done",      32'(m_if.done), 32'd1);
        chk("t2_end_valid", 32'(m_if.ser_valid), 32'd0);
        chk("t2_end_out",   32'(m_if.ser_out), 32'd0);
        chk("t2_end_ready", 32'(m_if.load_ready), 32'd1);
        chk("t2_end_busy",  32'(m_if.busy), 32'd0);
        step;
        chk("t2_done_drop", 32'(m_if.done), 32'd0);

        // Same word with a 2-cycle stall after bit 2
        m_if.load_valid = 1'b1;
        step;
        m_if.load_valid = 1'b0;
        chk_bit("t3_bit0", m_if.ser_valid, m_if.ser_out, 1'b1);
        step;
        chk_bit("t3_bit1", m_if.ser_valid, m_if.ser_out, 1'b1);
        m_if.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step;
            chk($sformatf("t3_hold_valid%0d", i), 32'(m_if.ser_valid), 32'd0);
            chk($sformatf("t3_hold_out%0d", i),   32'(m_if.ser_out), 32'd1);
            chk($sformatf("t3_hold_busy%0d", i),  32'(m_if.busy), 32'd1);
            chk($sformatf("t3_hold_done%0d", i),  32'(m_if.done), 32'd0);
        end
        m_if.stall = 1'b0;
        step;
        chk_bit("t3_bit2", m_if.ser_valid, m_if.ser_out, 1'b0);
        step;
        chk_bit("t3_bit3", m_if.ser_valid, m_if.ser_out, 1'b1);
        step;
        chk("t3_done", 32'(m_if.done), 32'd1);
        step;

        // Reset in the middle of a word
        m_if.load_valid = 1'b1;
        step;
        m_if.load_valid = 1'b0;
        step;
        chk_bit("t1_bit1", m_if.ser_valid, m_if.ser_out, 1'b1);
        reset = 1'b0;
        #1;
        chk("t1_valid", 32'(m_if.ser_valid), 32'd0);
        chk("t1_busy",  32'(m_if.busy), 32'd0);
        chk("t1_ready", 32'(m_if.load_ready), 32'd1);
        chk("t1_done",  32'(m_if.done), 32'd0);
        step;
        chk("t1_done_in_rst", 32'(m_if.done), 32'd0);
        reset = 1'b1;
        step;
        chk("t1_done_after", 32'(m_if.done), 32'd0);
        chk("t1_valid_after", 32'(m_if.ser_valid), 32'd0);

        // LSB first, 0xA5, with an ignored load_valid pulse mid-word
        l_if.load_data = 8'hA5; l_if.load_len = 4'd8; l_if.load_valid = 1'b1;
        step;
        l_if.load_valid = 1'b0;
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk_bit($sformatf("t4_bit%0d", i), l_if.ser_valid, l_if.ser_out, pat[i]);
            chk($sformatf("t4_ready%0d", i), 32'(l_if.load_ready), 32'd0);
            if (i == 2) begin
                l_if.load_valid = 1'b1; l_if.load_data = 8'h3C; l_if.load_len = 4'd3;
            end
            if (i == 4) l_if.load_valid = 1'b0;
            step;
        end
        chk("t4_done",  32'(l_if.done), 32'd1);
        chk("t4_ready", 32'(l_if.load_ready), 32'd1);
        step;
        chk("t4_no_accept_valid", 32'(l_if.ser_valid), 32'd0);
        chk("t4_no_accept_busy",  32'(l_if.busy), 32'd0);
        chk("t4_done_drop",       32'(l_if.done), 32'd0);

        // Zero-length word
        m_if.load_data = 8'hFF; m_if.load_len = 4'd0; m_if.load_valid = 1'b1;
        step;
        m_if.load_valid = 1'b0;
        chk("t5_len0_done",  32'(m_if.done), 32'd1);
        chk("t5_len0_valid", 32'(m_if.ser_valid), 32'd0);
        chk("t5_len0_busy",  32'(m_if.busy), 32'd0);
        step;
        chk("t5_len0_drop",  32'(m_if.done), 32'd0);
        chk("t5_len0_valid2", 32'(m_if.ser_valid), 32'd0);

        // Oversized length clamps to 8 bits
        m_if.load_data = 8'h96; m_if.load_len = 4'd9; m_if.load_valid = 1'b1;
        step;
        m_if.load_valid = 1'b0;
        pat = 8'h96;
        for (int i = 0; i < 8; i++) begin
            chk_bit($sformatf("t5_bit%0d", i), m_if.ser_valid, m_if.ser_out, pat[7-i]);
            step;
        end
        chk("t5_len9_done",  32'(m_if.done), 32'd1);
        chk("t5_len9_valid", 32'(m_if.ser_valid), 32'd0);
        step;

        // Back-to-back words with load_valid held
        m_if.load_data = 8'h0D; m_if.load_len = 4'd4; m_if.load_valid = 1'b1;
        step;
        m_if.load_data = 8'h0B;
        pat = 8'h0D;
        for (int i = 0; i < 4; i++) begin
            chk_bit($sformatf("t6_w1_bit%0d", i), m_if.ser_valid, m_if.ser_out, pat[3-i]);
            step;
        end
        chk("t6_gap_done",  32'(m_if.done), 32'd1);
        chk("t6_gap_out",   32'(m_if.ser_out), 32'd0);
        chk("t6_gap_valid", 32'(m_if.ser_valid), 32'd0);
        step;
        m_if.load_valid = 1'b0;
        pat = 8'h0B;
        for (int i = 0; i < 4; i++) begin
            chk_bit($sformatf("t6_w2_bit%0d", i), m_if.ser_valid, m_if.ser_out, pat[3-i]);
            if (i == 0) chk("t6_w2_done_low", 32'(m_if.done), 32'd0);
            step;
        end
        chk("t6_done2", 32'(m_if.done), 32'd1);
        step;
        chk("t6_done2_drop", 32'(m_if.done), 32'd0);
        chk("t6_idle_busy",  32'(m_if.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
